// File: rtl/sram_rw_initiator_pkg.sv
// Shared definitions for the SRAM RW0 initiator: FSM states, RW0 write-mode
// encodings and a helper for sizing occupancy counters.
package sram_rw_initiator_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam logic WMODE_READ  = 1'b0;
  localparam logic WMODE_WRITE = 1'b1;

  // Bits needed to hold a count in the range 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_resp_fifo.sv
// Small circular FIFO holding read data returned by the SRAM until the
// response consumer takes it. Head is presented combinationally.
module sram_resp_fifo
  import sram_rw_initiator_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int WIDTH = 32,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_ok  = pop_i && (count_q != '0);
  assign valid_o = (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    rd_ptr_d = pop_ok ? next_ptr(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push_i ? next_ptr(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_i && pop_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once count says they exist.
  always_ff @(posedge clock) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  count_in_range_a: assert property (@(posedge clock) disable iff (reset)
    count_q <= FULL_CNT);

  no_push_when_full_a: assert property (@(posedge clock) disable iff (reset)
    !(push_i && (count_q == FULL_CNT) && !pop_ok));

endmodule

// File: rtl/sram_rw_initiator.sv
// Drives a single-port SRAM RW0 port from a request stream, returns read data
// through a credit-limited response FIFO, and zero-fills the array after reset.
module sram_rw_initiator
  import sram_rw_initiator_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int MASK_W     = 4,
  parameter int RESP_DEPTH = 3,
  parameter int INIT_ZERO  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_busy,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int CNT_W = cnt_width(RESP_DEPTH);
  localparam state_e RESET_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_READY;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(RESP_DEPTH);

  state_e            state_q;
  logic [ADDR_W-1:0] init_cnt_q;
  logic              inflight_q;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              accept;
  logic              rd_accept;
  logic              resp_pop;

  // Reads already issued plus data waiting in the FIFO; only registered terms,
  // so resp_ready never reaches req_ready combinationally.
  assign credit_used = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_q);
  assign req_ready   = !reset && (state_q == ST_READY) && (credit_used < CREDIT_LIMIT);
  assign accept      = req_valid && req_ready;
  assign rd_accept   = accept && (req_write == WMODE_READ);
  assign resp_pop    = resp_valid && resp_ready;
  assign init_busy   = (state_q == ST_INIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= RESET_STATE;
      init_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_accept;
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + ADDR_W'(1);
          if (init_cnt_q == LAST_ADDR) begin
            state_q <= ST_READY;
          end
        end
        ST_READY: begin
          state_q <= ST_READY;
        end
        default: begin
          state_q <= RESET_STATE;
        end
      endcase
    end
  end

  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = WMODE_READ;
    RW0_addr  = req_addr;
    RW0_wmask = req_wmask;
    RW0_wdata = req_wdata;
    if (!reset) begin
      if (state_q == ST_INIT) begin
        RW0_en    = 1'b1;
        RW0_wmode = WMODE_WRITE;
        RW0_addr  = init_cnt_q;
        RW0_wmask = '1;
        RW0_wdata = '0;
      end else if (accept) begin
        RW0_en    = 1'b1;
        RW0_wmode = req_write;
      end
    end
  end

  // The SRAM returns data the cycle after the read; capture is unconditional
  // because the credit check reserved a slot at accept time.
  sram_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_W),
    .CNT_W (CNT_W)
  ) u_resp_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (RW0_rdata),
    .pop_i       (resp_pop),
    .valid_o     (resp_valid),
    .head_o      (resp_rdata),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_sram_rw_initiator.sv
// Bench for sram_rw_initiator with a behavioural RW0 SRAM and a word-level
// memory model that predicts read responses in request order.
module tb_sram_rw_initiator;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int MW    = 4;
  localparam int LW    = DW / MW;
  localparam int DEPTH = 3;
  localparam int WORDS = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [MW-1:0] req_wmask;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          init_busy;
  logic [AW-1:0] RW0_addr;
  logic          RW0_en, RW0_wmode;
  logic [MW-1:0] RW0_wmask;
  logic [DW-1:0] RW0_wdata;
  logic [DW-1:0] RW0_rdata;
  logic          scramble_mem = 1'b0;

  logic [DW-1:0] sram_mem [WORDS];
  logic [DW-1:0] ref_mem [WORDS];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  sram_rw_initiator #(
    .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .RESP_DEPTH(DEPTH), .INIT_ZERO(1)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_busy(init_busy),
    .RW0_addr(RW0_addr), .RW0_en(RW0_en), .RW0_wmode(RW0_wmode),
    .RW0_wmask(RW0_wmask), .RW0_wdata(RW0_wdata), .RW0_rdata(RW0_rdata)
  );

  // RW0 macro: masked byte writes, registered read data, junk on other cycles.
  always @(posedge clock) begin
    if (scramble_mem) begin
      for (int i = 0; i < WORDS; i++) sram_mem[i] <= $urandom;
    end else if (RW0_en && RW0_wmode) begin
      for (int l = 0; l < MW; l++)
        if (RW0_wmask[l]) sram_mem[RW0_addr][l*LW +: LW] <= RW0_wdata[l*LW +: LW];
    end
    if (RW0_en && !RW0_wmode) RW0_rdata <= sram_mem[RW0_addr];
    else RW0_rdata <= $urandom;
  end

  // Called at the negedge: record what the coming edge transfers, then advance.
  task automatic commit();
    if (!reset) begin
      if (resp_valid && resp_ready) got_q.push_back(resp_rdata);
      if (req_valid && req_ready) begin
        if (req_write) begin
          for (int l = 0; l < MW; l++)
            if (req_wmask[l]) ref_mem[req_addr][l*LW +: LW] = req_wdata[l*LW +: LW];
        end else begin
          exp_q.push_back(ref_mem[req_addr]);
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
  endtask

  task automatic do_req(input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [MW-1:0] m);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
    for (int t = 0; t < 20; t++) begin
      @(negedge clock);
      if (req_ready) begin
        commit();
        req_valid = 1'b0;
        return;
      end
      commit();
    end
    total_cnt++;
    $display("FAIL req_timeout: request @%0d not accepted in 20 cycles", a);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    for (int t = 0; t < 30 && exp_q.size() != got_q.size(); t++) begin
      @(negedge clock);
      commit();
    end
    if (exp_q.size() != got_q.size()) begin
      total_cnt++;
      $display("FAIL drain_timeout: got %0d responses expected %0d", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_fill();
    logic [45:0] obs, want;
    reset = 1'b1; scramble_mem = 1'b1; resp_ready = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    scramble_mem = 1'b0;
    total_cnt++;
    if ({req_ready, resp_valid, init_busy, RW0_en, RW0_wmode} !== 5'b00100)
      $display("FAIL reset_values: got %b expected 00100",
               {req_ready, resp_valid, init_busy, RW0_en, RW0_wmode});
    else pass_cnt++;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clock);
      obs  = {init_busy, req_ready, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata, RW0_addr};
      want = {1'b1, 1'b0, 1'b1, 1'b1, 4'hF, 32'h0, AW'(i)};
      total_cnt++;
      if (obs !== want) $display("FAIL fill_cycle_%0d: got %h expected %h", i, obs, want);
      else pass_cnt++;
      commit();
    end
    @(negedge clock);
    total_cnt++;
    if ({init_busy, req_ready} !== 2'b01)
      $display("FAIL fill_done: got busy/ready %b expected 01", {init_busy, req_ready});
    else pass_cnt++;
    commit();
    resp_ready = 1'b1;
    do_req(1'b0, 6'd17, '0, '0);
    drain();
    total_cnt++;
    if (got_q.size() != 1 || got_q[0] !== 32'h0)
      $display("FAIL read_after_fill: got %0d responses, first %h expected 1 of 0", got_q.size(),
               got_q.size() > 0 ? got_q[0] : 32'hx);
    else pass_cnt++;
    model_reset_queues();
  endtask

  task automatic model_reset_queues();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_write_mask();
    resp_ready = 1'b1;
    do_req(1'b1, 6'd5, 32'hDEADBEEF, 4'hF);
    do_req(1'b1, 6'd5, 32'h000000AA, 4'h1);
    do_req(1'b0, 6'd5, '0, '0);
    drain();
    total_cnt++;
    if (got_q.size() != 1 || got_q[0] !== 32'hDEADBEAA)
      $display("FAIL write_mask: got %h expected deadbeaa", got_q.size() > 0 ? got_q[0] : 32'hx);
    else pass_cnt++;
    model_reset_queues();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) do_req(1'b1, AW'(i), DW'(i * 3), 4'hF);
    resp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      req_valid = (k < 10); req_write = 1'b0; req_addr = AW'(k);
      @(negedge clock);
      if (k < 10) begin
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL b2b_ready_%0d: got %b expected 1", k, req_ready);
        else pass_cnt++;
      end
      total_cnt++;
      if (resp_valid !== (k >= 2))
        $display("FAIL b2b_valid_%0d: got %b expected %b", k, resp_valid, k >= 2);
      else pass_cnt++;
      if (k >= 2) begin
        total_cnt++;
        if (resp_rdata !== DW'((k - 2) * 3))
          $display("FAIL b2b_data_%0d: got %h expected %h", k, resp_rdata, DW'((k - 2) * 3));
        else pass_cnt++;
      end
      commit();
    end
    drain();
    total_cnt++;
    if (got_q.size() != 10) $display("FAIL b2b_count: got %0d expected 10", got_q.size());
    else pass_cnt++;
    model_reset_queues();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] wr_data [6];
    int next, acc_stall;
    for (int i = 0; i < 6; i++) begin
      wr_data[i] = $urandom;
      do_req(1'b1, AW'(20 + i), wr_data[i], 4'hF);
    end
    resp_ready = 1'b0;
    next = 0; acc_stall = 0;
    for (int t = 0; t < 6; t++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(20 + next);
      @(negedge clock);
      if (req_ready) begin
        acc_stall++;
        commit();
        next++;
      end else commit();
    end
    @(negedge clock);
    total_cnt++;
    if (acc_stall != 3 || req_ready !== 1'b0 || resp_valid !== 1'b1)
      $display("FAIL bp_stall: got accepts=%0d ready=%b valid=%b expected 3 0 1",
               acc_stall, req_ready, resp_valid);
    else pass_cnt++;
    resp_ready = 1'b1;
    commit();
    for (int t = 0; t < 20 && next < 6; t++) begin
      req_valid = 1'b1; req_addr = AW'(20 + next);
      @(negedge clock);
      if (req_ready) begin
        commit();
        next++;
      end else commit();
    end
    total_cnt++;
    if (next != 6) $display("FAIL bp_resume: got %0d accepted expected 6", next);
    else pass_cnt++;
    drain();
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (got_q.size() <= i || got_q[i] !== wr_data[i])
        $display("FAIL bp_data_%0d: got %h expected %h", i, got_q.size() > i ? got_q[i] : 32'hx, wr_data[i]);
      else pass_cnt++;
    end
    model_reset_queues();
  endtask

  task automatic test_order();
    resp_ready = 1'b1;
    do_req(1'b0, 6'd8, '0, '0);
    do_req(1'b1, 6'd8, 32'h55, 4'hF);
    do_req(1'b0, 6'd8, '0, '0);
    drain();
    total_cnt++;
    if (got_q.size() != 2 || got_q[0] !== 32'd24 || got_q[1] !== 32'h55)
      $display("FAIL order: got %0d resps %h %h expected 00000018 00000055", got_q.size(),
               got_q.size() > 0 ? got_q[0] : 32'hx, got_q.size() > 1 ? got_q[1] : 32'hx);
    else pass_cnt++;
    model_reset_queues();
  endtask

  task automatic test_random();
    logic exp_ready;
    for (int t = 0; t < 300; t++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_write  = $urandom_range(0, 1) != 0;
      req_addr   = AW'($urandom_range(0, 15));
      req_wdata  = $urandom;
      req_wmask  = MW'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      exp_ready = (exp_q.size() - got_q.size()) < DEPTH;
      total_cnt++;
      if (req_ready !== exp_ready) $display("FAIL rand_ready_%0d: got %b expected %b", t, req_ready, exp_ready);
      else pass_cnt++;
      total_cnt++;
      if (RW0_en !== (req_valid && exp_ready))
        $display("FAIL rand_en_%0d: got %b expected %b", t, RW0_en, req_valid && exp_ready);
      else pass_cnt++;
      commit();
    end
    drain();
    for (int i = 0; i < exp_q.size(); i++) begin
      total_cnt++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i])
        $display("FAIL rand_resp_%0d: got %h expected %h", i, got_q.size() > i ? got_q[i] : 32'hx, exp_q[i]);
      else pass_cnt++;
    end
    model_reset_queues();
  endtask

  task automatic test_reset_abort();
    resp_ready = 1'b0;
    do_req(1'b0, 6'd3, '0, '0);
    do_req(1'b0, 6'd4, '0, '0);
    repeat (2) begin @(negedge clock); commit(); end
    @(negedge clock);
    total_cnt++;
    if (resp_valid !== 1'b1) $display("FAIL abort_pre: got valid %b expected 1", resp_valid);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({resp_valid, init_busy, req_ready, RW0_en} !== 4'b0100)
      $display("FAIL abort_reset: got %b expected 0100", {resp_valid, init_busy, req_ready, RW0_en});
    else pass_cnt++;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      total_cnt++;
      if (RW0_addr !== AW'(i) || RW0_en !== 1'b1)
        $display("FAIL refill_a_%0d: got addr %0d en %b expected %0d 1", i, RW0_addr, RW0_en, i);
      else pass_cnt++;
      commit();
    end
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if (RW0_en !== 1'b0) $display("FAIL abort_fill_en: got %b expected 0", RW0_en);
    else pass_cnt++;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      @(negedge clock);
      total_cnt++;
      if (RW0_addr !== AW'(i) || RW0_en !== 1'b1 || init_busy !== 1'b1)
        $display("FAIL refill_b_%0d: got addr %0d en %b busy %b expected %0d 1 1",
                 i, RW0_addr, RW0_en, init_busy, i);
      else pass_cnt++;
      commit();
    end
    @(negedge clock);
    total_cnt++;
    if ({init_busy, req_ready} !== 2'b01)
      $display("FAIL refill_done: got %b expected 01", {init_busy, req_ready});
    else pass_cnt++;
    commit();
    resp_ready = 1'b1;
    do_req(1'b0, 6'd3, '0, '0);
    drain();
    total_cnt++;
    if (got_q.size() != 1 || got_q[0] !== 32'h0)
      $display("FAIL refill_read: got %h expected 0", got_q.size() > 0 ? got_q[0] : 32'hx);
    else pass_cnt++;
    model_reset_queues();
  endtask

  initial begin
    test_reset_fill();
    test_write_mask();
    test_back_to_back();
    test_backpressure();
    test_order();
    test_random();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
